// File: rtl/game_state_manager.sv
// ============================================================================
// game_state_manager : game flow FSM (idle/play/death/win/lose), score, lives
//                      and level countdown for a frame-driven arcade game.
// Revision: 1.0
// ============================================================================
`default_nettype none

module game_state_manager #(
  parameter int FRAMES_PER_SEC = 30,
  parameter int LEVEL_TIME     = 60,
  parameter int INIT_LIVES     = 3,
  parameter int FRUIT_POINTS   = 10,
  parameter int GOAL_POINTS    = 100,
  parameter int FREEZE_FRAMES  = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       startKey,
  input  logic       fruitHitPulse,
  input  logic       goalHitPulse,
  output logic [2:0] gameState,
  output logic [9:0] score,
  output logic [1:0] lives,
  output logic [6:0] timeSec,
  output logic       freezeMonkey,
  output logic       levelRestart
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    DEATH = 3'd2,
    WIN   = 3'd3,
    LOSE  = 3'd4
  } state_t;

  localparam int FRAME_W  = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam int FREEZE_W = (FREEZE_FRAMES > 1) ? $clog2(FREEZE_FRAMES) : 1;

  localparam logic [FRAME_W-1:0]  FRAME_LAST  = FRAME_W'(FRAMES_PER_SEC - 1);
  localparam logic [FREEZE_W-1:0] FREEZE_LAST = FREEZE_W'(FREEZE_FRAMES - 1);
  localparam logic [6:0]          TIME_INIT   = 7'(LEVEL_TIME);
  localparam logic [1:0]          LIVES_INIT  = 2'(INIT_LIVES);
  localparam logic [9:0]          SCORE_MAX   = 10'd999;

  state_t              state_q, state_d;
  logic [9:0]          score_q, score_d;
  logic [1:0]          lives_q, lives_d;
  logic [6:0]          time_q, time_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic [FREEZE_W-1:0] freeze_q, freeze_d;
  logic                restart_q, restart_d;
  logic [31:0]         points;

  function automatic logic [9:0] sat_add(input logic [9:0] base, input logic [31:0] pts);
    logic [31:0] sum;
    sum = 32'(base) + pts;
    if (sum > 32'd999) return SCORE_MAX;
    return sum[9:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      score_q   <= '0;
      lives_q   <= LIVES_INIT;
      time_q    <= TIME_INIT;
      frame_q   <= '0;
      freeze_q  <= '0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      time_q    <= time_d;
      frame_q   <= frame_d;
      freeze_q  <= freeze_d;
      restart_q <= restart_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    lives_d   = lives_q;
    time_d    = time_q;
    frame_d   = frame_q;
    freeze_d  = freeze_q;
    restart_d = 1'b0;
    points    = (fruitHitPulse ? 32'(FRUIT_POINTS) : 32'd0)
              + (goalHitPulse  ? 32'(GOAL_POINTS)  : 32'd0);

    case (state_q)
      IDLE: begin
        if (startKey) begin
          state_d   = PLAY;
          score_d   = '0;
          lives_d   = LIVES_INIT;
          time_d    = TIME_INIT;
          frame_d   = '0;
          restart_d = 1'b1;
        end
      end

      PLAY: begin
        if (fruitHitPulse || goalHitPulse) begin
          score_d = sat_add(score_q, points);
        end
        // A goal wins outright and freezes the clock, even on the expiry tick.
        if (goalHitPulse) begin
          state_d = WIN;
        end else if (startOfFrame) begin
          if (frame_q == FRAME_LAST) begin
            frame_d = '0;
            if (time_q <= 7'd1) begin
              time_d   = '0;
              state_d  = DEATH;
              lives_d  = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
              freeze_d = '0;
            end else begin
              time_d = time_q - 7'd1;
            end
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end

      DEATH: begin
        if (startOfFrame) begin
          if (freeze_q == FREEZE_LAST) begin
            freeze_d = '0;
            if (lives_q == 2'd0) begin
              state_d = LOSE;
            end else begin
              state_d   = PLAY;
              time_d    = TIME_INIT;
              frame_d   = '0;
              restart_d = 1'b1;
            end
          end else begin
            freeze_d = freeze_q + 1'b1;
          end
        end
      end

      WIN, LOSE: begin
        if (startKey) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign gameState    = state_q;
  assign score        = score_q;
  assign lives        = lives_q;
  assign timeSec      = time_q;
  assign levelRestart = restart_q;
  assign freezeMonkey = (state_q != PLAY);

endmodule

`default_nettype wire

// File: tb/tb_game_state_manager.sv
// ============================================================================
// tb_game_state_manager : scenario tasks with a queue-based scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_game_state_manager;

  localparam int FPS = 30;
  localparam int LT  = 2;
  localparam int IL  = 3;
  localparam int FP  = 10;
  localparam int GP  = 100;
  localparam int FF  = 60;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PLAY  = 3'd1;
  localparam logic [2:0] S_DEATH = 3'd2;
  localparam logic [2:0] S_WIN   = 3'd3;
  localparam logic [2:0] S_LOSE  = 3'd4;

  logic       clk = 1'b0;
  logic       reset, sof, sk, fr, gl;
  logic [2:0] gameState;
  logic [9:0] score;
  logic [1:0] lives;
  logic [6:0] timeSec;
  logic       freezeMonkey, levelRestart;

  game_state_manager #(
    .FRAMES_PER_SEC(FPS), .LEVEL_TIME(LT), .INIT_LIVES(IL),
    .FRUIT_POINTS(FP), .GOAL_POINTS(GP), .FREEZE_FRAMES(FF)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(sof), .startKey(sk),
    .fruitHitPulse(fr), .goalHitPulse(gl), .gameState(gameState),
    .score(score), .lives(lives), .timeSec(timeSec),
    .freezeMonkey(freezeMonkey), .levelRestart(levelRestart)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic [9:0] sc;
    logic [1:0] lv;
    logic [6:0] tm;
    logic       rs;
    logic       fz;
  } snap_t;

  snap_t exp_q[$];
  snap_t obs_q[$];
  string nm_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic snap_t mk(input logic [2:0] st, input int sc, input int lv,
                               input int tm, input bit rs);
    snap_t s;
    s.st = st;
    s.sc = 10'(sc);
    s.lv = 2'(lv);
    s.tm = 7'(tm);
    s.rs = rs;
    s.fz = (st != S_PLAY);
    return s;
  endfunction

  function automatic snap_t observe();
    snap_t s;
    s.st = gameState;
    s.sc = score;
    s.lv = lives;
    s.tm = timeSec;
    s.rs = levelRestart;
    s.fz = freezeMonkey;
    return s;
  endfunction

  // One clock of stimulus; optionally queue an expectation and record the result.
  task automatic step(input bit s_sof, input bit s_sk, input bit s_fr, input bit s_gl,
                      input bit chk, input snap_t e, input string n);
    if (chk) begin
      exp_q.push_back(e);
      nm_q.push_back(n);
    end
    sof = s_sof; sk = s_sk; fr = s_fr; gl = s_gl;
    @(posedge clk);
    #1;
    sof = 1'b0; sk = 1'b0; fr = 1'b0; gl = 1'b0;
    if (chk) obs_q.push_back(observe());
  endtask

  task automatic frames(input int n, input bit fruit);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, fruit, 1'b0, 1'b0, '0, "");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, "");
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; sof = 1'b0; sk = 1'b0; fr = 1'b0; gl = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(mk(S_IDLE, 0, IL, LT, 1'b0));
    nm_q.push_back("reset_hold");
    obs_q.push_back(observe());
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, mk(S_IDLE, 0, IL, LT, 1'b0), "idle_after_reset");
    while (exp_q.size() != 0) begin
      snap_t e, o; string n;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d sc=%0d lv=%0d tm=%0d rs=%0d fz=%0d want st=%0d sc=%0d lv=%0d tm=%0d rs=%0d fz=%0d",
                 n, o.st, o.sc, o.lv, o.tm, o.rs, o.fz, e.st, e.sc, e.lv, e.tm, e.rs, e.fz);
      end
    end
  endtask

  task automatic test_start_fruit();
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, mk(S_PLAY, 0, IL, LT, 1'b1), "start_play");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(S_PLAY, 0, IL, LT, 1'b0), "restart_one_clk");
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, mk(S_PLAY, FP * i, IL, LT, 1'b0), "fruit_add");
      frames(1, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, mk(S_PLAY, 30, IL, LT, 1'b0), "start_ignored_play");
    while (exp_q.size() != 0) begin
      snap_t e, o; string n;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d sc=%0d lv=%0d tm=%0d rs=%0d fz=%0d want st=%0d sc=%0d lv=%0d tm=%0d rs=%0d fz=%0d",
                 n, o.st, o.sc, o.lv, o.tm, o.rs, o.fz, e.st, e.sc, e.lv, e.tm, e.rs, e.fz);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, "");
    frames(FPS - 1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(S_PLAY, 0, IL, 2, 1'b0), "time_2");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, mk(S_PLAY, 0, IL, 1, 1'b0), "time_1");
    frames(FPS - 1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, mk(S_DEATH, 0, IL - 1, 0, 1'b0), "death_entry");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, mk(S_DEATH, 0, IL - 1, 0, 1'b0), "start_ignored_death");
    frames(FF - 1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(S_DEATH, 0, IL - 1, 0, 1'b0), "death_hold");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, mk(S_PLAY, 0, IL - 1, LT, 1'b1), "replay_restart");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(S_PLAY, 0, IL - 1, LT, 1'b0), "replay_pulse_end");
    while (exp_q.size() != 0) begin
      snap_t e, o; string n;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d sc=%0d lv=%0d tm=%0d rs=%0d fz=%0d want st=%0d sc=%0d lv=%0d tm=%0d rs=%0d fz=%0d",
                 n, o.st, o.sc, o.lv, o.tm, o.rs, o.fz, e.st, e.sc, e.lv, e.tm, e.rs, e.fz);
      end
    end
  endtask

  task automatic test_lose();
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, "");
    for (int l = IL - 1; l >= 0; l--) begin
      frames(LT * FPS - 1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, mk(S_DEATH, 0, l, 0, 1'b0), "death_lives");
      frames(FF - 1, 1'b0);
      if (l == 0)
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, mk(S_LOSE, 0, 0, 0, 1'b0), "lose_entry");
      else
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, mk(S_PLAY, 0, l, LT, 1'b1), "life_replay");
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, mk(S_LOSE, 0, 0, 0, 1'b0), "lose_ignore_hits");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, mk(S_IDLE, 0, 0, 0, 1'b0), "lose_to_idle");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, mk(S_PLAY, 0, IL, LT, 1'b1), "idle_restart");
    while (exp_q.size() != 0) begin
      snap_t e, o; string n;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d sc=%0d lv=%0d tm=%0d rs=%0d fz=%0d want st=%0d sc=%0d lv=%0d tm=%0d rs=%0d fz=%0d",
                 n, o.st, o.sc, o.lv, o.tm, o.rs, o.fz, e.st, e.sc, e.lv, e.tm, e.rs, e.fz);
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, "");
    frames(LT * FPS - 1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, mk(S_DEATH, 590, IL - 1, 0, 1'b0), "sat_death_keeps_score");
    frames(FF - 1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, mk(S_PLAY, 590, IL - 1, LT, 1'b1), "sat_replay");
    frames(36, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(S_PLAY, 950, IL - 1, 1, 1'b0), "score_950");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, mk(S_WIN, 999, IL - 1, 1, 1'b0), "fruit_goal_saturate");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, mk(S_WIN, 999, IL - 1, 1, 1'b0), "win_fruit_ignored");
    frames(FPS, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(S_WIN, 999, IL - 1, 1, 1'b0), "win_time_frozen");
    while (exp_q.size() != 0) begin
      snap_t e, o; string n;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d sc=%0d lv=%0d tm=%0d rs=%0d fz=%0d want st=%0d sc=%0d lv=%0d tm=%0d rs=%0d fz=%0d",
                 n, o.st, o.sc, o.lv, o.tm, o.rs, o.fz, e.st, e.sc, e.lv, e.tm, e.rs, e.fz);
      end
    end
  endtask

  task automatic test_goal_expiry();
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, "");
    frames(LT * FPS - 1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, mk(S_WIN, GP, IL, 1, 1'b0), "goal_beats_expiry");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, mk(S_IDLE, GP, IL, 1, 1'b0), "win_to_idle_holds");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, mk(S_PLAY, 0, IL, LT, 1'b1), "idle_to_play_clears");
    while (exp_q.size() != 0) begin
      snap_t e, o; string n;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d sc=%0d lv=%0d tm=%0d rs=%0d fz=%0d want st=%0d sc=%0d lv=%0d tm=%0d rs=%0d fz=%0d",
                 n, o.st, o.sc, o.lv, o.tm, o.rs, o.fz, e.st, e.sc, e.lv, e.tm, e.rs, e.fz);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, "");
    frames(LT * FPS - 1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, mk(S_DEATH, 0, IL - 1, 0, 1'b0), "pre_reset_death");
    frames(5, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back(mk(S_IDLE, 0, IL, LT, 1'b0));
    nm_q.push_back("async_reset_death");
    obs_q.push_back(observe());
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, mk(S_IDLE, 0, IL, LT, 1'b0), "idle_ignore_hits");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, mk(S_PLAY, 0, IL, LT, 1'b1), "start_after_reset");
    frames(3, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back(mk(S_IDLE, 0, IL, LT, 1'b0));
    nm_q.push_back("async_reset_play");
    obs_q.push_back(observe());
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, mk(S_PLAY, 0, IL, LT, 1'b1), "first_clk_start");
    while (exp_q.size() != 0) begin
      snap_t e, o; string n;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d sc=%0d lv=%0d tm=%0d rs=%0d fz=%0d want st=%0d sc=%0d lv=%0d tm=%0d rs=%0d fz=%0d",
                 n, o.st, o.sc, o.lv, o.tm, o.rs, o.fz, e.st, e.sc, e.lv, e.tm, e.rs, e.fz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_fruit();
    test_timeout();
    test_lose();
    test_saturate();
    test_goal_expiry();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
